usr_ctrl: RTL and testbench

Command-driven sequencer for a SIZE-bit universal shift register (4:1 mux per bit, select {sel1,sel0}, clear_n-reset DFFs). Accepts load, shift and rotate commands over a valid/ready handshake. Drives the register's select, serial-fill and parallel-data inputs for the required number of cycles. Signals completion with a one-cycle done pulse. Sits between a host FSM or bus slave and one shift-register instance, and is its only driver.

---
 rtl/usr_ctrl_pkg.sv | 30 +++
 rtl/usr_ctrl_if.sv | 42 ++++
 rtl/usr_ctrl_cnt.sv | 42 ++++
 rtl/usr_ctrl.sv | 159 +++++++++++++++
 tb/tb_usr_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/usr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usr_ctrl_pkg
//  Description : Shared encodings for the universal shift register sequencer:
//                command opcodes, register select codes and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package usr_ctrl_pkg;

   // Command opcodes carried on cmd_op
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SHR  = 2'b01;
   localparam logic [1:0] OP_SHL  = 2'b10;
   localparam logic [1:0] OP_ROR  = 2'b11;

   // Register mux selects {sel1,sel0}
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHR  = 2'b01;
   localparam logic [1:0] SEL_SHL  = 2'b10;
   localparam logic [1:0] SEL_LOAD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage
`default_nettype wire

// File: rtl/usr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : usr_ctrl_if
//  Description : Command handshake plus shift-register drive/feedback bundle
//                between the host environment and usr_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface usr_ctrl_if #(
   parameter int SIZE = 4,
   parameter int AW   = $clog2(SIZE + 1)
);
   // command side
   logic            cmd_valid;
   logic            cmd_ready;
   logic [1:0]      cmd_op;
   logic [AW-1:0]   cmd_amt;
   logic            cmd_fill;
   logic [SIZE-1:0] cmd_data;
   logic            abort;
   logic            busy;
   logic            done;
   logic            err;
   // shift register side
   logic [SIZE-1:0] usr_q;
   logic [1:0]      usr_sel;
   logic            usr_left;
   logic            usr_right;
   logic [SIZE-1:0] usr_d;

   // Host / register environment
   modport master (
      output cmd_valid, cmd_op, cmd_amt, cmd_fill, cmd_data, abort, usr_q,
      input  cmd_ready, busy, done, err, usr_sel, usr_left, usr_right, usr_d
   );

   // Sequencer
   modport slave (
      input  cmd_valid, cmd_op, cmd_amt, cmd_fill, cmd_data, abort, usr_q,
      output cmd_ready, busy, done, err, usr_sel, usr_left, usr_right, usr_d
   );
endinterface
`default_nettype wire

// File: rtl/usr_ctrl_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : usr_ctrl_cnt
//  Description : Loadable down-counter for remaining shift cycles, with a
//                flag marking the final cycle (count = 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module usr_ctrl_cnt #(
   parameter int AW = 3
) (
   input  wire logic          clk,
   input  wire logic          clear_n,
   input  wire logic          load,
   input  wire logic [AW-1:0] load_val,
   input  wire logic          dec,
   output logic      [AW-1:0] cnt,
   output logic               last
);
   localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0] cnt_q;
   logic [AW-1:0] cnt_d;

   // Load wins over decrement; never wrap below zero
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - CNT_ONE;
   end

   // Count register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_ONE);
endmodule
`default_nettype wire

// File: rtl/usr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : usr_ctrl
//  Description : Command sequencer for a SIZE-bit universal shift register.
//                Accepts LOAD/SHR/SHL/ROR over valid/ready, drives the
//                register select, serial fills and load data, and pulses
//                done when the result is in the register.
//                Build macro USR_CTRL_ROTATE_EN enables ROR; without it op 11
//                completes immediately with an err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module usr_ctrl
   import usr_ctrl_pkg::*;
#(
   parameter int SIZE = 4
) (
   input wire logic   clk,
   input wire logic   clear_n,
   usr_ctrl_if.slave  bus
);
   localparam int AW = $clog2(SIZE + 1);
   localparam logic [AW-1:0] SIZE_AMT = AW'(SIZE);

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic            fill_q, fill_d;
   logic            err_q, err_d;
   logic [SIZE-1:0] usr_d_q, usr_d_d;

   logic [AW-1:0]   amt_clamped;
   logic [AW-1:0]   cnt;
   logic            cnt_last;
   logic            cnt_load;
   logic            cnt_dec;
   logic [1:0]      sel;
   logic            left_bit;
   logic            right_bit;

   // Oversized shift counts saturate to a full-width shift
   assign amt_clamped = (bus.cmd_amt > SIZE_AMT) ? SIZE_AMT : bus.cmd_amt;

   usr_ctrl_cnt #(.AW(AW)) u_cnt (
      .clk      (clk),
      .clear_n  (clear_n),
      .load     (cnt_load),
      .load_val (amt_clamped),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .last     (cnt_last)
   );

   // Next-state logic; command fields are captured only on the handshake edge
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      fill_d   = fill_q;
      err_d    = err_q;
      usr_d_d  = usr_d_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            err_d = 1'b0;
            if (bus.cmd_valid) begin
               if (bus.cmd_op == OP_LOAD) begin
                  usr_d_d = bus.cmd_data;
                  state_d = ST_LOAD;
               end else begin
                  op_d   = bus.cmd_op;
                  fill_d = bus.cmd_fill;
`ifdef USR_CTRL_ROTATE_EN
                  if (amt_clamped == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_load = 1'b1;
                     state_d  = ST_SHIFT;
                  end
`else
                  if (bus.cmd_op == OP_ROR) begin
                     // Rotate not built in: complete at once and flag it
                     err_d   = 1'b1;
                     state_d = ST_DONE;
                  end else if (amt_clamped == '0) begin
                     state_d = ST_DONE;
                  end else begin
                     cnt_load = 1'b1;
                     state_d  = ST_SHIFT;
                  end
`endif
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_DONE;
         end
         ST_SHIFT: begin
            cnt_dec = 1'b1;
            if (bus.abort || cnt_last)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control registers
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LOAD;
         fill_q  <= 1'b0;
         err_q   <= 1'b0;
         usr_d_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         fill_q  <= fill_d;
         err_q   <= err_d;
         usr_d_q <= usr_d_d;
      end
   end

   // Register drive; abort forces hold in the same cycle, unselected fills are 0
   always_comb begin
      sel       = SEL_HOLD;
      left_bit  = 1'b0;
      right_bit = 1'b0;
      unique case (state_q)
         ST_LOAD: sel = SEL_LOAD;
         ST_SHIFT: begin
            if (!bus.abort) begin
               if (op_q == OP_SHL) begin
                  sel      = SEL_SHL;
                  left_bit = fill_q;
               end else begin
                  sel       = SEL_SHR;
                  right_bit = (op_q == OP_ROR) ? bus.usr_q[0] : fill_q;
               end
            end
         end
         default: sel = SEL_HOLD;
      endcase
   end

   assign bus.usr_sel   = sel;
   assign bus.usr_left  = left_bit;
   assign bus.usr_right = right_bit;
   assign bus.usr_d     = usr_d_q;
   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.err       = (state_q == ST_DONE) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_usr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usr_ctrl
//  Description : Directed self-checking bench for usr_ctrl driving a
//                behavioural 4-bit universal shift register.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_ctrl;
   localparam int SIZE = 4;

   logic clk;
   logic clear_n;
   logic reg_clr_n;
   int   n_cmp;
   int   n_err;

   usr_ctrl_if #(.SIZE(SIZE)) bus ();

   usr_ctrl #(.SIZE(SIZE)) dut (
      .clk     (clk),
      .clear_n (clear_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural universal shift register with its own clear
   always_ff @(posedge clk or negedge reg_clr_n) begin
      if (!reg_clr_n) bus.usr_q <= '0;
      else begin
         case (bus.usr_sel)
            2'b01:   bus.usr_q <= {bus.usr_right, bus.usr_q[SIZE-1:1]};
            2'b10:   bus.usr_q <= {bus.usr_q[SIZE-2:0], bus.usr_left};
            2'b11:   bus.usr_q <= bus.usr_d;
            default: bus.usr_q <= bus.usr_q;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer one command, wait for the handshake edge, then scramble the fields
   task automatic send(input logic [1:0] op, input logic [2:0] amt,
                       input logic fill, input logic [3:0] data);
      int t;
      t = 0;
      while (!bus.cmd_ready && t < 20) begin
         step();
         t++;
      end
      if (t >= 20) chk("ready_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_amt   = amt;
      bus.cmd_fill  = fill;
      bus.cmd_data  = data;
      step();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_amt   = 3'($urandom);
      bus.cmd_fill  = 1'($urandom);
      bus.cmd_data  = 4'($urandom);
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      clear_n       = 1'b0;
      reg_clr_n     = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_amt   = 3'd0;
      bus.cmd_fill  = 1'b0;
      bus.cmd_data  = 4'h0;
      bus.abort     = 1'b0;
      step();
      step();
      // reset state
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.done),      32'd0);
      chk("rst_err",   32'(bus.err),       32'd0);
      chk("rst_sel",   32'(bus.usr_sel),   32'd0);
      chk("rst_lr",    32'({bus.usr_left, bus.usr_right}), 32'd0);
      chk("rst_usrd",  32'(bus.usr_d),     32'd0);
      clear_n   = 1'b1;
      reg_clr_n = 1'b1;
      step();

      // LOAD 1011
      send(2'b00, 3'd0, 1'b0, 4'b1011);
      chk("ld_c1_sel",   32'(bus.usr_sel),   32'd3);
      chk("ld_c1_busy",  32'(bus.busy),      32'd1);
      chk("ld_c1_ready", 32'(bus.cmd_ready), 32'd0);
      chk("ld_c1_done",  32'(bus.done),      32'd0);
      chk("ld_c1_usrd",  32'(bus.usr_d),     32'hB);
      step();
      chk("ld_c2_done",  32'(bus.done),      32'd1);
      chk("ld_c2_sel",   32'(bus.usr_sel),   32'd0);
      chk("ld_c2_q",     32'(bus.usr_q),     32'hB);
      step();
      chk("ld_c3_ready", 32'(bus.cmd_ready), 32'd1);
      chk("ld_c3_done",  32'(bus.done),      32'd0);

      // SHL 2 fill 1 from 1011 -> 0111 -> 1111
      send(2'b10, 3'd2, 1'b1, 4'h0);
      chk("shl_c1_sel",  32'(bus.usr_sel), 32'd2);
      chk("shl_c1_lr",   32'({bus.usr_left, bus.usr_right}), 32'b10);
      step();
      chk("shl_c2_sel",  32'(bus.usr_sel), 32'd2);
      chk("shl_c2_done", 32'(bus.done),    32'd0);
      step();
      chk("shl_c3_done", 32'(bus.done),    32'd1);
      chk("shl_c3_q",    32'(bus.usr_q),   32'hF);
      step();

      // SHR 7 (clamps to 4) fill 0 from 1011 -> 0000
      send(2'b00, 3'd0, 1'b0, 4'b1011);
      step();
      step();
      send(2'b01, 3'd7, 1'b0, 4'h0);
      for (int i = 1; i <= 4; i++) begin
         chk("shr7_sel",  32'(bus.usr_sel), 32'd1);
         chk("shr7_done", 32'(bus.done),    32'd0);
         step();
      end
      chk("shr7_c5_done", 32'(bus.done),  32'd1);
      chk("shr7_c5_q",    32'(bus.usr_q), 32'h0);
      step();

      // ROR 1 from 1011
      send(2'b00, 3'd0, 1'b0, 4'b1011);
      step();
      step();
      send(2'b11, 3'd1, 1'b0, 4'h0);
`ifdef USR_CTRL_ROTATE_EN
      chk("ror_c1_sel",   32'(bus.usr_sel),   32'd1);
      chk("ror_c1_right", 32'(bus.usr_right), 32'd1);
      step();
      chk("ror_c2_done",  32'(bus.done),  32'd1);
      chk("ror_c2_err",   32'(bus.err),   32'd0);
      chk("ror_c2_q",     32'(bus.usr_q), 32'hD);
`else
      chk("ror_c1_done",  32'(bus.done),    32'd1);
      chk("ror_c1_err",   32'(bus.err),     32'd1);
      chk("ror_c1_sel",   32'(bus.usr_sel), 32'd0);
      chk("ror_c1_q",     32'(bus.usr_q),   32'hB);
`endif
      step();
      chk("ror_idle_err", 32'(bus.err), 32'd0);

      // SHR 4 fill 0 from 1011, abort in cycle 2 -> one shift -> 0101
      send(2'b00, 3'd0, 1'b0, 4'b1011);
      step();
      step();
      send(2'b01, 3'd4, 1'b0, 4'h0);
      chk("abt_c1_sel", 32'(bus.usr_sel), 32'd1);
      step();
      bus.abort = 1'b1;
      #1;
      chk("abt_c2_sel", 32'(bus.usr_sel), 32'd0);
      chk("abt_c2_lr",  32'({bus.usr_left, bus.usr_right}), 32'd0);
      step();
      bus.abort = 1'b0;
      chk("abt_c3_done", 32'(bus.done),  32'd1);
      chk("abt_c3_q",    32'(bus.usr_q), 32'h5);
      step();

      // SHR 0 -> no shift, done in cycle 1
      send(2'b01, 3'd0, 1'b1, 4'h0);
      chk("shr0_c1_done", 32'(bus.done),    32'd1);
      chk("shr0_c1_err",  32'(bus.err),     32'd0);
      chk("shr0_c1_sel",  32'(bus.usr_sel), 32'd0);
      chk("shr0_c1_q",    32'(bus.usr_q),   32'h5);
      step();

      // Reset mid-shift: SHR 4 fill 1 from 0101, one shift -> 1010
      send(2'b01, 3'd4, 1'b1, 4'h0);
      chk("rmid_c1_right", 32'(bus.usr_right), 32'd1);
      step();
      clear_n = 1'b0;
      #1;
      chk("rmid_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rmid_busy",  32'(bus.busy),      32'd0);
      chk("rmid_sel",   32'(bus.usr_sel),   32'd0);
      chk("rmid_right", 32'(bus.usr_right), 32'd0);
      chk("rmid_usrd",  32'(bus.usr_d),     32'd0);
      #2;
      clear_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rmid_nodone", 32'(bus.done),  32'd0);
         chk("rmid_q",      32'(bus.usr_q), 32'hA);
      end
      send(2'b00, 3'd0, 1'b0, 4'b0110);
      chk("post_c1_sel",  32'(bus.usr_sel), 32'd3);
      step();
      chk("post_c2_done", 32'(bus.done),    32'd1);
      chk("post_c2_q",    32'(bus.usr_q),   32'h6);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
